// File: rtl/bpm_tracker_pkg.sv
// rtl/bpm_tracker_pkg.sv - shared types and widths for the tempo tracker
package bpm_tracker_pkg;

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} tracker_state_t;

    localparam int ACC_W = 40;
    localparam int INC_W = 24;
    localparam int BPM_W = 16;

    function automatic int sum_w(input int depth);
        return BPM_W + $clog2(depth);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int DIVIDEND_W = 56,
    parameter int DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVISOR_W:0]    w_trial;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_fits;

    // r_quo holds the unconsumed dividend bits at the top and the quotient at the bottom
    always_comb begin
        w_trial = {r_rem, r_quo[DIVIDEND_W-1]};
        w_diff  = w_trial - {1'b0, r_dvs};
        w_fits  = (w_trial >= {1'b0, r_dvs});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= '0;
                r_dvs  <= divisor;
                r_quo  <= dividend;
                r_cnt  <= CNT_W'(DIVIDEND_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_fits ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
                r_quo <= {r_quo[DIVIDEND_W-2:0], w_fits};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quo;

endmodule

// File: rtl/bpm_tempo_tracker.sv
// rtl/bpm_tempo_tracker.sv - BPM range check, outlier rejection, averaging, lock and beat generation
module bpm_tempo_tracker
    import bpm_tracker_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int BPM_MIN       = 60,
    parameter int BPM_MAX       = 200,
    parameter int AVG_DEPTH     = 8,
    parameter int JUMP_THRESH   = 20,
    parameter int CONFIRM_COUNT = 3,
    parameter int TIMEOUT_BEATS = 16,
    parameter int PHASE_INC_W   = INC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm_in,
    input  logic             bpm_in_valid,
    output logic [BPM_W-1:0] bpm_smoothed,
    output logic             tempo_locked,
    output logic             beat_pulse,
    output logic [7:0]       beat_phase,
    output logic             sample_rejected
);
    localparam int LOG2_D     = $clog2(AVG_DEPTH);
    localparam int SUM_W      = sum_w(AVG_DEPTH);
    localparam int DIVIDEND_W = BPM_W + ACC_W;
    localparam int DIVISOR_W  = 32;
    localparam int CONF_W     = $clog2(CONFIRM_COUNT + 1);
    localparam int BEAT_W     = $clog2(TIMEOUT_BEATS + 1);
    localparam logic [BPM_W-1:0] MIN_V  = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] MAX_V  = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] JUMP_V = BPM_W'(JUMP_THRESH);
    localparam longint unsigned  DIV_L  = 64'(60) * 64'(CLK_HZ);
    localparam logic [DIVISOR_W-1:0] DIVISOR_V = DIVISOR_W'(DIV_L);

    tracker_state_t r_state, w_next_state;

    logic [BPM_W-1:0]       r_buf [AVG_DEPTH];
    logic [LOG2_D-1:0]      r_wr_ptr;
    logic [LOG2_D:0]        r_fill;
    logic [SUM_W-1:0]       r_sum;
    logic [BPM_W-1:0]       r_avg;
    logic [BPM_W-1:0]       r_cand;
    logic [CONF_W-1:0]      r_cand_cnt;
    logic [BEAT_W-1:0]      r_beats;
    logic                   r_rej;
    logic                   r_div_start;
    logic [PHASE_INC_W-1:0] r_inc;
    logic [ACC_W-1:0]       r_acc;
    logic                   r_pulse;

    logic                   w_in_range, w_out_range, w_write, w_cand, w_agree, w_retrack;
    logic                   w_timeout, w_fill_last, w_inc_load;
    logic [BPM_W-1:0]       w_dev, w_cand_dev, w_avg_wr;
    logic [CONF_W-1:0]      w_cnt_next;
    logic [SUM_W-1:0]       w_sum_wr;
    logic [ACC_W:0]         w_acc_sum;
    logic                   w_div_busy, w_div_done;
    logic [DIVIDEND_W-1:0]  w_quotient;
    logic [PHASE_INC_W-1:0] w_inc_sat;

    always_comb begin
        w_in_range  = bpm_in_valid && (bpm_in >= MIN_V) && (bpm_in <= MAX_V);
        w_out_range = bpm_in_valid && !w_in_range;
        w_dev       = (bpm_in >= r_avg) ? bpm_in - r_avg : r_avg - bpm_in;
        w_cand_dev  = (bpm_in >= r_cand) ? bpm_in - r_cand : r_cand - bpm_in;
        w_write     = w_in_range && ((r_state != LOCKED) || (w_dev <= JUMP_V));
        w_cand      = w_in_range && (r_state == LOCKED) && (w_dev > JUMP_V);
        w_agree     = (r_cand_cnt == '0) || (w_cand_dev <= JUMP_V);
        w_cnt_next  = w_agree ? r_cand_cnt + 1'b1 : CONF_W'(1);
        w_retrack   = w_cand && (w_cnt_next >= CONF_W'(CONFIRM_COUNT));
        w_sum_wr    = r_sum + SUM_W'(bpm_in) - SUM_W'(r_buf[r_wr_ptr]);
        w_avg_wr    = w_sum_wr[SUM_W-1:LOG2_D];
        w_fill_last = (r_fill == (LOG2_D + 1)'(AVG_DEPTH - 1));
        // an accepted sample in the same cycle as the last beat keeps the lock
        w_timeout   = (r_state == LOCKED) && r_pulse && !w_write && !w_retrack &&
                      (r_beats == BEAT_W'(TIMEOUT_BEATS - 1));
        w_acc_sum   = {1'b0, r_acc} + (ACC_W + 1)'(r_inc);
        w_inc_sat   = (|w_quotient[DIVIDEND_W-1:PHASE_INC_W]) ? '1 : w_quotient[PHASE_INC_W-1:0];
        w_inc_load  = (r_state == LOCKED) && w_div_done && !w_div_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_write) w_next_state = ACQUIRE;
            ACQUIRE: if (w_write && w_fill_last) w_next_state = LOCKED;
            LOCKED:  if (w_timeout) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        tempo_locked    = (r_state == LOCKED);
        bpm_smoothed    = tempo_locked ? r_avg : '0;
        beat_pulse      = r_pulse;
        beat_phase      = r_acc[ACC_W-1 -: 8];
        sample_rejected = r_rej;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_cand      <= '0;
            r_cand_cnt  <= '0;
            r_beats     <= '0;
            r_rej       <= 1'b0;
            r_div_start <= 1'b0;
            r_inc       <= '0;
            r_acc       <= '0;
            r_pulse     <= 1'b0;
        end else begin
            r_rej       <= w_out_range || w_cand;
            r_div_start <= 1'b0;
            if (w_timeout) begin
                for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= '0;
                r_wr_ptr   <= '0;
                r_fill     <= '0;
                r_sum      <= '0;
                r_avg      <= '0;
                r_cand     <= '0;
                r_cand_cnt <= '0;
                r_beats    <= '0;
                r_inc      <= '0;
                r_acc      <= '0;
                r_pulse    <= 1'b0;
            end else begin
                if (w_write) begin
                    r_buf[r_wr_ptr] <= bpm_in;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    r_sum           <= w_sum_wr;
                    r_avg           <= w_avg_wr;
                    r_cand_cnt      <= '0;
                    if (r_state != LOCKED) r_fill <= r_fill + 1'b1;
                    r_div_start <= (w_next_state == LOCKED) &&
                                   ((r_state != LOCKED) || (w_avg_wr != r_avg));
                end else if (w_cand) begin
                    r_cand <= bpm_in;
                    if (w_retrack) begin
                        for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= bpm_in;
                        r_sum       <= SUM_W'(bpm_in) << LOG2_D;
                        r_avg       <= bpm_in;
                        r_cand_cnt  <= '0;
                        r_div_start <= 1'b1;
                    end else begin
                        r_cand_cnt <= w_cnt_next;
                    end
                end
                if (r_state == LOCKED) begin
                    if (w_write || w_retrack) r_beats <= '0;
                    else if (r_pulse)         r_beats <= r_beats + 1'b1;
                end
                if (w_inc_load) r_inc <= w_inc_sat;
                // the new increment applies from the next add, so the phase never jumps
                if ((r_state == LOCKED) && (r_inc != '0)) begin
                    r_acc   <= w_acc_sum[ACC_W-1:0];
                    r_pulse <= w_acc_sum[ACC_W];
                end else begin
                    r_pulse <= 1'b0;
                end
            end
        end
    end

    seq_divider #(
        .DIVIDEND_W(DIVIDEND_W),
        .DIVISOR_W (DIVISOR_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (r_div_start),
        .dividend({r_avg, ACC_W'(0)}),
        .divisor (DIVISOR_V),
        .busy    (w_div_busy),
        .done    (w_div_done),
        .quotient(w_quotient)
    );

endmodule

// File: tb/tb_bpm_tempo_tracker.sv
// tb/tb_bpm_tempo_tracker.sv - scoreboard testbench for bpm_tempo_tracker
module tb_bpm_tempo_tracker;

    localparam int CLK_HZ = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bpm_in = '0;
    logic        bpm_in_valid = 1'b0;
    logic [15:0] bpm_smoothed;
    logic        tempo_locked;
    logic        beat_pulse;
    logic [7:0]  beat_phase;
    logic        sample_rejected;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        rej;
        logic        lk;
        logic [15:0] sm;
    } exp_t;
    exp_t sb[$];

    int m_state;
    int m_buf[8];
    int m_ptr, m_fill, m_cand, m_cnt;

    bpm_tempo_tracker #(
        .CLK_HZ     (CLK_HZ),
        .PHASE_INC_W(32)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .bpm_in         (bpm_in),
        .bpm_in_valid   (bpm_in_valid),
        .bpm_smoothed   (bpm_smoothed),
        .tempo_locked   (tempo_locked),
        .beat_pulse     (beat_pulse),
        .beat_phase     (beat_phase),
        .sample_rejected(sample_rejected)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int m_avg();
        int s = 0;
        for (int i = 0; i < 8; i++) s += m_buf[i];
        return s / 8;
    endfunction

    task automatic m_clear();
        m_state = 0; m_ptr = 0; m_fill = 0; m_cand = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_buf[i] = 0;
        sb.delete();
    endtask

    task automatic model_push(input int v);
        exp_t e;
        e.rej = 1'b0;
        if (v < 60 || v > 200) begin
            e.rej = 1'b1;
        end else if (m_state != 2) begin
            m_buf[m_ptr] = v; m_ptr = (m_ptr + 1) % 8; m_fill++;
            m_state = (m_fill == 8) ? 2 : 1;
        end else if (absd(v, m_avg()) <= 20) begin
            m_buf[m_ptr] = v; m_ptr = (m_ptr + 1) % 8; m_cnt = 0;
        end else begin
            e.rej = 1'b1;
            if (m_cnt == 0 || absd(v, m_cand) <= 20) m_cnt++;
            else m_cnt = 1;
            m_cand = v;
            if (m_cnt >= 3) begin
                for (int i = 0; i < 8; i++) m_buf[i] = v;
                m_cnt = 0;
            end
        end
        e.lk = (m_state == 2);
        e.sm = e.lk ? 16'(m_avg()) : 16'd0;
        sb.push_back(e);
    endtask

    task automatic send(input int v);
        exp_t e;
        model_push(v);
        @(negedge clk);
        bpm_in = 16'(v);
        bpm_in_valid = 1'b1;
        @(posedge clk); #1;
        bpm_in_valid = 1'b0;
        e = sb.pop_front();
        n_tests += 3;
        if (sample_rejected !== e.rej) begin
            n_fail++;
            $display("FAIL rejected(bpm=%0d): got %0b expected %0b", v, sample_rejected, e.rej);
        end
        if (tempo_locked !== e.lk) begin
            n_fail++;
            $display("FAIL locked(bpm=%0d): got %0b expected %0b", v, tempo_locked, e.lk);
        end
        if (bpm_smoothed !== e.sm) begin
            n_fail++;
            $display("FAIL smoothed(bpm=%0d): got %0d expected %0d", v, bpm_smoothed, e.sm);
        end
    endtask

    task automatic wait_pulse(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (beat_pulse === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bpm_smoothed, tempo_locked, beat_pulse, beat_phase, sample_rejected} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bpm_smoothed, tempo_locked, beat_pulse, beat_phase, sample_rejected});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_range();
        send(40);
        send(250);
        send(59);
        send(201);
    endtask

    task automatic test_clean_lock();
        int lock_cyc, p1, p2, p3, ph0, prev, maxp;
        bit mono;
        for (int i = 0; i < 8; i++) send(120);
        lock_cyc = cyc;
        wait_pulse(3300, p1);
        ph0 = beat_phase;
        n_tests++;
        if (p1 < 0 || (p1 - lock_cyc) < 3045 || (p1 - lock_cyc) > 3075) begin
            n_fail++;
            $display("FAIL first_pulse_latency: got %0d expected 3045..3075", (p1 < 0) ? -1 : p1 - lock_cyc);
        end
        n_tests++;
        if (ph0 != 0) begin
            n_fail++;
            $display("FAIL phase_at_pulse: got %0d expected 0", ph0);
        end
        mono = 1'b1; maxp = 0; prev = ph0; p2 = -1;
        for (int i = 0; i < 3300; i++) begin
            @(posedge clk); #1;
            if (beat_pulse === 1'b1) begin
                p2 = cyc;
                break;
            end
            if (beat_phase < prev) mono = 1'b0;
            if (beat_phase > maxp) maxp = beat_phase;
            prev = beat_phase;
        end
        n_tests++;
        if (!mono || maxp != 255) begin
            n_fail++;
            $display("FAIL phase_ramp: got monotonic=%0b max=%0d expected 1 and 255", mono, maxp);
        end
        n_tests++;
        if (p2 < 0 || p1 < 0 || (p2 - p1) < 2999 || (p2 - p1) > 3001) begin
            n_fail++;
            $display("FAIL interval_120_a: got %0d expected 3000+-1", (p2 < 0 || p1 < 0) ? -1 : p2 - p1);
        end
        wait_pulse(3300, p3);
        n_tests++;
        if (p3 < 0 || p2 < 0 || (p3 - p2) < 2999 || (p3 - p2) > 3001) begin
            n_fail++;
            $display("FAIL interval_120_b: got %0d expected 3000+-1", (p3 < 0 || p2 < 0) ? -1 : p3 - p2);
        end
    endtask

    task automatic test_outlier();
        send(180);
        send(120);
        send(120);
        send(120);
        send(125);
    endtask

    task automatic test_retrack();
        int p0, p1, p2, p3;
        wait_pulse(3300, p0);
        send(90);
        send(90);
        send(90);
        wait_pulse(4300, p1);
        wait_pulse(4300, p2);
        wait_pulse(4300, p3);
        n_tests++;
        if (p0 < 0 || p1 < 0 || (p1 - p0) < 2999 || (p1 - p0) > 4001) begin
            n_fail++;
            $display("FAIL switch_interval: got %0d expected 2999..4001", (p0 < 0 || p1 < 0) ? -1 : p1 - p0);
        end
        n_tests++;
        if (p1 < 0 || p2 < 0 || (p2 - p1) < 3999 || (p2 - p1) > 4001) begin
            n_fail++;
            $display("FAIL interval_90_a: got %0d expected 4000+-1", (p1 < 0 || p2 < 0) ? -1 : p2 - p1);
        end
        n_tests++;
        if (p2 < 0 || p3 < 0 || (p3 - p2) < 3999 || (p3 - p2) > 4001) begin
            n_fail++;
            $display("FAIL interval_90_b: got %0d expected 4000+-1", (p2 < 0 || p3 < 0) ? -1 : p3 - p2);
        end
    endtask

    task automatic test_reset_mid();
        send(100);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bpm_smoothed, tempo_locked, beat_pulse, beat_phase, sample_rejected} !== 27'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {bpm_smoothed, tempo_locked, beat_pulse, beat_phase, sample_rejected});
        end
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(120);
    endtask

    task automatic test_timeout();
        int p;
        bit ok;
        ok = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_pulse(3400, p);
            if (p < 0) begin
                ok = 1'b0;
                break;
            end
            if (k == 15) begin
                n_tests++;
                if (tempo_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL locked_after_15_beats: got %0b expected 1", tempo_locked);
                end
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_beats: got fewer than 16 pulses expected 16");
        end
        @(posedge clk); #1;
        n_tests++;
        if (tempo_locked !== 1'b0 || bpm_smoothed !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_unlock: got locked=%0b smoothed=%0d expected 0 and 0",
                     tempo_locked, bpm_smoothed);
        end
        m_clear();
        wait_pulse(3500, p);
        n_tests++;
        if (p >= 0 || beat_phase !== 8'd0) begin
            n_fail++;
            $display("FAIL silent_after_timeout: got pulse_at=%0d phase=%0d expected -1 and 0", p, beat_phase);
        end
        send(120);
    endtask

    initial begin
        test_reset();
        test_range();
        test_clean_lock();
        test_outlier();
        test_retrack();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bpm_tempo_tracker.md
Name: bpm_tempo_tracker

Overview:
- Downstream consumer of the BPM estimator's final_BPM_estimate stream.
- Range-checks raw estimates, rejects single-frame outliers, smooths over a moving average and declares tempo lock.
- While locked, a phase accumulator generates a free-running beat_pulse and beat_phase at the smoothed tempo, for the visual/LED and sync logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BPM_MIN, 60, lowest accepted BPM; smaller inputs are rejected.
- BPM_MAX, 200, highest accepted BPM; larger inputs are rejected.
- AVG_DEPTH, 8, moving-average length in samples; power of 2, range 2..32.
- JUMP_THRESH, 20, BPM deviation treated as a tempo-change candidate.
- CONFIRM_COUNT, 3, consecutive agreeing candidates required to retrack.
- TIMEOUT_BEATS, 16, beat pulses with no accepted sample before lock is dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- bpm_in  in  16  raw BPM estimate, unsigned integer.
- bpm_in_valid  in  1  single-cycle qualifier for bpm_in.
- bpm_smoothed  out  16  moving-average BPM; 0 when not locked.
- tempo_locked  out  1  high in LOCKED state.
- beat_pulse  out  1  single-cycle pulse once per beat period while locked.
- beat_phase  out  8  position within the current beat, 0..255.
- sample_rejected  out  1  single-cycle pulse when bpm_in_valid is out of range or an outlier is dropped.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset is low, all outputs are 0 and the FSM is IDLE. Assertion mid-operation clears the ring buffer, sum, counters, accumulator and divider immediately.
- Acceptance: a sample is in range when BPM_MIN <= bpm_in <= BPM_MAX. An out-of-range sample raises sample_rejected on the next cycle and changes no state.
- Ring buffer: AVG_DEPTH x 16 bits, with running sum of 16+log2(AVG_DEPTH) bits. Sum update is sum + new − oldest. bpm_smoothed = sum >> log2(AVG_DEPTH), registered 1 cycle after the accepting valid.
- FSM IDLE: the first accepted sample is written to the buffer, fill count = 1, go to ACQUIRE.
- FSM ACQUIRE: accepted samples are written. When fill count reaches AVG_DEPTH, go to LOCKED and start the divider. bpm_smoothed reads 0 until LOCKED.
- FSM LOCKED, normal sample: |bpm_in − bpm_smoothed| <= JUMP_THRESH → sample written; candidate count cleared.
- FSM LOCKED, candidate sample: a sample exceeding JUMP_THRESH is a candidate and is not written; sample_rejected pulses.
  - The candidate is stored if count is 0, or it is within JUMP_THRESH of the stored candidate; count increments.
  - A candidate disagreeing with the stored one replaces it and sets count = 1.
  - When count reaches CONFIRM_COUNT, every buffer entry is loaded with the latest candidate (sum = cand × AVG_DEPTH), count clears, the FSM stays LOCKED and the divider restarts.
- Timeout: in LOCKED, a counter increments on each beat_pulse and clears on each accepted sample. Reaching TIMEOUT_BEATS → IDLE, with buffer, accumulator and outputs cleared.
- Divider: phase_inc = (bpm_smoothed << 40) / (60 × CLK_HZ).
  - Sequential restoring divider: 56-bit dividend, 32-bit divisor, 1 quotient bit per cycle, done 57 cycles after start.
  - It is started whenever bpm_smoothed changes in LOCKED. A start while busy aborts and restarts.
  - phase_inc, 24 bits, is updated only on done.
- Accumulator: 40-bit acc += phase_inc every cycle while LOCKED and phase_inc != 0. Carry out of bit 39 → beat_pulse = 1 for that cycle. beat_phase = acc[39:32].
- A new phase_inc takes effect the cycle after done, with no phase reset, so there are no glitch or double pulses.
- On LOCKED entry, acc = 0. The first pulse therefore comes one full period after the first phase_inc is loaded.
- Simultaneous events: bpm_in_valid coinciding with a divider done — the sample is processed and the divider restarts the next cycle. A timeout and an accepted sample in the same cycle — the sample wins; counter clears, lock is kept.

Decomposition:
- Package bpm_tracker_pkg: typedef enum {IDLE, ACQUIRE, LOCKED} tracker_state_t; constants ACC_W = 40 and INC_W = 24; function clog2-based SUM_W.
- Sub-module seq_divider (parameters DIVIDEND_W, DIVISOR_W): ports start, dividend, divisor, busy, done, quotient.

Test Plan:
- Clean lock, CLK_HZ = 6000: 8 samples of 120 → tempo_locked rises 1 cycle after the 8th; bpm_smoothed = 120; beat_pulse intervals are 3000 ±1 clocks; beat_phase ramps 0..255 per beat.
- Range: bpm_in = 40, then 250 → sample_rejected pulses twice; FSM stays IDLE; fill count stays 0.
- Outlier: locked at 120, a single 180 followed by 120s → bpm_smoothed stays 120; one sample_rejected pulse; no retrack.
- Retrack: locked at 120, three 90s → bpm_smoothed = 90 after the 3rd; phase_inc is updated within 58 cycles; beat interval becomes 4000 ±1 clocks; no double pulse at the switch.
- Timeout: lock at 120, then stop input → after 16 beat_pulses, tempo_locked = 0, bpm_smoothed = 0 and beat_pulse stays silent.
- Reset mid-operation: drop reset mid-divide while locked → all outputs 0 asynchronously; after release, 8 new samples are needed to re-lock.
